// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the LSU data-RAM port.
// funct3 codes, FSM states and funct3 legality check.
package lsu_mem_port_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_CAP,
        ST_RESP
    } state_t;

    function automatic logic f3_bad(input logic we, input logic [2:0] f3);
        if (we)
            return f3 > F3_W;
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Byte-lane steering for the LSU: store enables/data and
// load merge, alignment and sign/zero extension.
module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic        split,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output logic [31:0] rdata
);

    logic [2:0]  size;
    logic [3:0]  mask;
    logic [31:0] r32;
    logic        sx;

    always_comb begin
        size = 3'd4;
        mask = 4'b1111;
        unique case (funct3[1:0])
            2'd0: begin
                size = 3'd1;
                mask = 4'b0001;
            end
            2'd1: begin
                size = 3'd2;
                mask = 4'b0011;
            end
            default: ;
        endcase
    end

    assign split = ({1'b0, off} + size) > 3'd4;
    assign be8   = {4'b0000, mask} << off;
    assign wd64  = {32'b0, wdata} << {off, 3'b000};
    assign r32   = 32'({hi, lo} >> {off, 3'b000});
    assign sx    = ~funct3[2];

    always_comb begin
        rdata = r32;
        unique case (funct3[1:0])
            2'd0:    rdata = {{24{sx & r32[7]}}, r32[7:0]};
            2'd1:    rdata = {{16{sx & r32[15]}}, r32[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU initiator for the byte-enabled word RAM; one request at a time,
// word-crossing accesses split into two word cycles.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  mem_w_enable,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data
);

    localparam logic [31:0] MW = 32'(MEM_WORDS);

    state_t      state, state_n;
    logic        we_q, split_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [29:0] a_q;
    logic [31:0] lo_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;

    logic        idle, accept, split, dec_err;
    logic [2:0]  f3_s;
    logic [1:0]  off_s;
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] ld_data, lo_s, a_ext, a_nxt;

    assign idle      = state == ST_IDLE;
    assign req_ready = idle;
    assign accept    = req_valid & idle;

    // Align unit sees the live request at accept, the latched one after
    assign f3_s  = idle ? req_funct3 : f3_q;
    assign off_s = idle ? req_addr[1:0] : off_q;
    assign lo_s  = split_q ? lo_q : mem_r_data;
    assign a_ext = {2'b00, req_addr[31:2]};
    assign a_nxt = {2'b00, a_q + 30'd1};

    assign dec_err = f3_bad(req_we, req_funct3)
                   | (a_ext >= MW)
                   | (split & (a_ext + 32'd1 >= MW));

    lsu_align u_align (
        .funct3 (f3_s),
        .off    (off_s),
        .wdata  (req_wdata),
        .lo     (lo_s),
        .hi     (mem_r_data),
        .split  (split),
        .be8    (be8),
        .wd64   (wd64),
        .rdata  (ld_data)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (accept) state_n = dec_err ? ST_RESP : ST_ACC0;
            ST_ACC0: state_n = split_q ? ST_ACC1 : (we_q ? ST_RESP : ST_CAP);
            ST_ACC1: state_n = we_q ? ST_RESP : ST_CAP;
            ST_CAP:  state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            split_q      <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            a_q          <= '0;
            lo_q         <= '0;
            be_hi_q      <= '0;
            wd_hi_q      <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_w_enable <= '0;
            mem_w_addr   <= '0;
            mem_w_data   <= '0;
            mem_r_addr   <= '0;
        end else begin
            mem_w_enable <= '0;
            resp_valid   <= state_n == ST_RESP;
            unique case (state)
                ST_IDLE: if (accept) begin
                    we_q       <= req_we;
                    f3_q       <= req_funct3;
                    off_q      <= req_addr[1:0];
                    a_q        <= req_addr[31:2];
                    split_q    <= split;
                    be_hi_q    <= be8[7:4];
                    wd_hi_q    <= wd64[63:32];
                    resp_rdata <= '0;
                    resp_err   <= dec_err;
                    if (!dec_err) begin
                        if (req_we) begin
                            mem_w_addr   <= a_ext;
                            mem_w_enable <= be8[3:0];
                            mem_w_data   <= wd64[31:0];
                        end else begin
                            mem_r_addr <= a_ext;
                        end
                    end
                end
                ST_ACC0: if (split_q) begin
                    if (we_q) begin
                        mem_w_addr   <= a_nxt;
                        mem_w_enable <= be_hi_q;
                        mem_w_data   <= wd_hi_q;
                    end else begin
                        mem_r_addr <= a_nxt;
                    end
                end
                ST_ACC1: if (!we_q) lo_q <= mem_r_data;
                ST_CAP:  resp_rdata <= ld_data;
                ST_RESP: resp_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural byte-enabled RAM.
// Checks enables, addresses, load results, latency, errors and reset abort.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  mem_w_enable;
    logic [31:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;

    int ncmp = 0;
    int nfail = 0;

    logic [31:0] ram [0:32767];
    logic [3:0]  lg_we [0:7];
    logic [31:0] lg_wa [0:7];
    logic [31:0] lg_wd [0:7];
    logic [31:0] lg_ra [0:7];
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        seen;

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_w_enable (mem_w_enable),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_addr   (mem_r_addr),
        .mem_r_data   (mem_r_data)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_w_enable[b])
                ram[mem_w_addr[14:0]][8*b +: 8] <= mem_w_data[8*b +: 8];
        mem_r_data <= ram[mem_r_addr[14:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, log mem outputs per cycle after accept until resp
    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
        int k;
        k = 0;
        while (!req_ready && k < 10) begin
            step();
            k++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'd7;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
        lat = 0;
        for (int n = 0; n < 8; n++) begin
            lg_we[n] = mem_w_enable;
            lg_wa[n] = mem_w_addr;
            lg_wd[n] = mem_w_data;
            lg_ra[n] = mem_r_addr;
            if (resp_valid) break;
            step();
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        if (!resp_valid) begin
            ncmp++;
            nfail++;
            $error("FAIL timeout: observed no resp expected resp_valid");
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_wen", 32'(mem_w_enable), 32'h0);
        chk("rst_waddr", mem_w_addr, 32'h0);
        chk("rst_wdata", mem_w_data, 32'h0);
        chk("rst_raddr", mem_r_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        run(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_wen", 32'(lg_we[0]), 32'hF);
        chk("sw_waddr", lg_wa[0], 32'h40);
        chk("sw_wdata", lg_wd[0], 32'hDEADBEEF);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_wen_resp", 32'(lg_we[1]), 32'h0);
        run(1'b0, 3'd2, 32'h100, 32'h0);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_raddr", lg_ra[0], 32'h40);
        chk("lw_data", rd, 32'hDEADBEEF);

        run(1'b1, 3'd0, 32'h103, 32'h000000A5);
        chk("sb_wen", 32'(lg_we[0]), 32'h8);
        chk("sb_wdata", lg_wd[0], 32'hA5000000);
        run(1'b0, 3'd0, 32'h103, 32'h0);
        chk("lb_data", rd, 32'hFFFFFFA5);
        run(1'b0, 3'd4, 32'h103, 32'h0);
        chk("lbu_data", rd, 32'h000000A5);

        run(1'b1, 3'd2, 32'h100, 32'h11223344);
        run(1'b1, 3'd2, 32'h104, 32'h55667788);
        run(1'b0, 3'd2, 32'h102, 32'h0);
        chk("lws_lat", 32'(lat), 32'd3);
        chk("lws_raddr0", lg_ra[0], 32'h40);
        chk("lws_raddr1", lg_ra[1], 32'h41);
        chk("lws_data", rd, 32'h77881122);

        run(1'b1, 3'd1, 32'h103, 32'h0000BEEF);
        chk("shs_lat", 32'(lat), 32'd2);
        chk("shs_waddr0", lg_wa[0], 32'h40);
        chk("shs_wen0", 32'(lg_we[0]), 32'h8);
        chk("shs_wdata0", lg_wd[0], 32'hEF000000);
        chk("shs_waddr1", lg_wa[1], 32'h41);
        chk("shs_wen1", 32'(lg_we[1]), 32'h1);
        chk("shs_wdata1", lg_wd[1], 32'h000000BE);
        chk("shs_wen_resp", 32'(lg_we[2]), 32'h0);
        run(1'b0, 3'd5, 32'h103, 32'h0);
        chk("lhu_data", rd, 32'h0000BEEF);
        run(1'b0, 3'd1, 32'h103, 32'h0);
        chk("lh_data", rd, 32'hFFFFBEEF);

        run(1'b0, 3'd3, 32'h100, 32'h0);
        chk("bad_f3_lat", 32'(lat), 32'd0);
        chk("bad_f3_err", 32'(er), 32'd1);
        chk("bad_f3_rdata", rd, 32'h0);
        chk("bad_f3_wen", 32'(lg_we[0]), 32'h0);
        run(1'b0, 3'd2, 32'h0002_0000, 32'h0);
        chk("oor_lw_err", 32'(er), 32'd1);
        chk("oor_lw_rdata", rd, 32'h0);
        run(1'b1, 3'd1, 32'h0001_FFFF, 32'h1234);
        chk("oor_sh_err", 32'(er), 32'd1);
        chk("oor_sh_wen", 32'(lg_we[0]), 32'h0);
        run(1'b1, 3'd3, 32'h100, 32'h0);
        chk("bad_sf3_err", 32'(er), 32'd1);
        run(1'b1, 3'd2, 32'h0001_FFFC, 32'hCAFEF00D);
        chk("top_sw_err", 32'(er), 32'd0);
        run(1'b0, 3'd2, 32'h0001_FFFC, 32'h0);
        chk("top_lw_err", 32'(er), 32'd0);
        chk("top_lw_data", rd, 32'hCAFEF00D);
        chk("rdata_after_err", rd, 32'hCAFEF00D);

        step();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h102;
        step();
        req_valid = 1'b0;
        step();
        chk("abort_acc1_raddr", mem_r_addr, 32'h41);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_raddr", mem_r_addr, 32'h0);
        chk("abort_wen", 32'(mem_w_enable), 32'h0);
        chk("abort_rvalid", 32'(resp_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (resp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (resp_valid) seen = 1'b1;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        run(1'b0, 3'd2, 32'h104, 32'h0);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_data", rd, 32'h556677BE);

        step();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h100;
        step();
        req_addr = 32'h104;
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("busy_raddr0", mem_r_addr, 32'h40);
        step();
        step();
        chk("busy_resp", 32'(resp_valid), 32'd1);
        chk("busy_data0", resp_rdata, 32'hEF223344);
        chk("busy_ready_resp", 32'(req_ready), 32'd0);
        step();
        chk("busy_idle_ready", 32'(req_ready), 32'd1);
        chk("busy_not_taken", mem_r_addr, 32'h40);
        step();
        req_valid = 1'b0;
        chk("busy_raddr1", mem_r_addr, 32'h41);
        step();
        step();
        chk("busy_resp1", 32'(resp_valid), 32'd1);
        chk("busy_data1", resp_rdata, 32'h556677BE);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
